// File: rtl/bus_memory_responder.sv
// Purpose : word-organised RAM target on the external CPU bus; latches the address phase,
//           services byte/half/word stores and full-word loads, drives io_bus only when selected.
// Latency : stores commit on the access edge; load data is valid one cycle after the address phase.
// Backpressure: none; the bus has no stall, illegal accesses are suppressed and raise bus_error.
// Optional feature: define ALIGN_CHECK_EN to flag misaligned half/word accesses as errors;
//   without it, misaligned accesses are force-aligned with no error.
// Ports:
//   clock          single clock, rising edge
//   reset          asynchronous active-low reset (memory contents are kept)
//   io_bus         32-bit bidirectional data, driven only for a selected legal read
//   address_bus    byte address, sampled when write_address=1
//   data_size      00 byte, 01 half, 10 word, 11 reserved (error)
//   write_address  address phase strobe (priority over read/write)
//   write / read   store / load strobes
//   selected       latched address hit this region
//   bus_error      sticky error flag, cleared only by reset
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [31:0] io_bus,
  input  logic [31:0] address_bus,
  input  logic [1:0]  data_size,
  input  logic        write_address,
  input  logic        write,
  input  logic        read,
  output logic        selected,
  output logic        bus_error
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_ADDRESSED = 1'b1;

  logic [0:0]       state_q;
  // Region-relative byte offset; BASE_ADDR alignment makes the low bits equal the bus address bits.
  logic [IDX_W+1:0] addr_q;
  logic [1:0]       size_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      off_in;
  logic             hit_in;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             access_vld;
  logic             misalign;
  logic             size_ok;
  logic             err_set;
  logic             store_en;
  logic             drive_en;
  logic [3:0]       lane_mask;

  // Unsigned 32-bit subtraction wraps, so addresses below BASE_ADDR land far above SPAN.
  assign off_in = address_bus - BASE_ADDR;
  assign hit_in = ({1'b0, off_in} < SPAN);

  assign idx  = addr_q[IDX_W+1:2];
  assign lane = addr_q[1:0];

  // write_address wins over read/write in the same cycle.
  assign access_vld = (state_q == ST_ADDRESSED) && selected && !write_address;

`ifdef ALIGN_CHECK_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign size_ok  = (size_q != 2'b11) && !misalign;
  assign err_set  = access_vld && ((read && write) || ((read || write) && !size_ok));
  assign store_en = access_vld && write && !read && size_ok;
  assign drive_en = access_vld && read && !write && size_ok;

  // Half-word always uses the lane pair picked by addr_q[1]: identical for aligned
  // accesses and gives the force-align behaviour when the alignment check is off.
  always_comb begin
    lane_mask = 4'b1111;
    case (size_q)
      2'b00:   lane_mask = 4'b0001 << lane;
      2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Memory is never reset; async reset forces state_q to IDLE, which already blocks store_en.
  always_ff @(posedge clock) begin
    if (store_en) begin
      for (int j = 0; j < 4; j++) begin
        if (lane_mask[j]) begin
          mem[idx][8*j +: 8] <= io_bus[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= 2'b00;
      selected  <= 1'b0;
      bus_error <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      if (write_address) begin
        addr_q   <= off_in[IDX_W+1:0];
        size_q   <= data_size;
        state_q  <= ST_ADDRESSED;
        selected <= hit_in;
      end
      if (err_set) begin
        bus_error <= 1'b1;
      end
      // Continuous prefetch: a store is visible in rdata_q on the following edge.
      if (state_q == ST_ADDRESSED) begin
        rdata_q <= mem[idx];
      end
    end
  end

  assign io_bus = drive_en ? rdata_q : 32'bz;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Purpose : directed and randomized check of bus_memory_responder against a byte-level model.
// Latency : inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: none; every step takes a fixed number of cycles.
module tb_bus_memory_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;
  tri   [31:0] io_bus;
  logic [31:0] address_bus;
  logic [1:0]  data_size;
  logic        write_address;
  logic        write;
  logic        read;
  logic        selected;
  logic        bus_error;

  logic        tb_drv;
  logic [31:0] tb_dat;

  assign io_bus = tb_drv ? tb_dat : 32'bz;

  always #5 clock = ~clock;

  bus_memory_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clock(clock), .reset(reset), .io_bus(io_bus), .address_bus(address_bus),
    .data_size(data_size), .write_address(write_address), .write(write), .read(read),
    .selected(selected), .bus_error(bus_error)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: region memory as bytes, plus the latched access context.
  logic [7:0]  mb [0:4*DEPTH-1];
  logic [31:0] m_addr;
  logic [1:0]  m_sz;
  bit          m_sel, m_act, m_err;

  function automatic bit f_hit(logic [31:0] a);
    return (a - BASE) < 32'(DEPTH * 4);
  endfunction

  function automatic bit f_legal();
`ifdef ALIGN_CHECK_EN
    if (m_sz == 2'd1 && m_addr[0]) return 1'b0;
    if (m_sz == 2'd2 && m_addr[1:0] != 2'd0) return 1'b0;
`endif
    return m_sz != 2'd3;
  endfunction

  function automatic logic [31:0] f_word(logic [31:0] a);
    int w;
    w = int'((a - BASE) & ~32'd3);
    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
  endfunction

  task automatic model_store(input logic [31:0] d);
    int off, eff, n, b;
    off = int'(m_addr - BASE);
    case (m_sz)
      2'd0:    eff = off;
      2'd1:    eff = off & ~1;
      default: eff = off & ~3;
    endcase
    n = 1 << m_sz;
    for (int j = 0; j < n; j++) begin
      b = eff + j;
      mb[b] = d[8*(b % 4) +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A released bus reads all-z, or all-zero on a two-state simulator.
  task automatic chk_float(input string tag);
    logic [31:0] o;
    o = io_bus;
    tests++;
    assert (o === 32'bz || o === 32'h0) else begin
      fails++;
      $error("FAIL %s: observed %h expected released bus", tag, o);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_err(input string tag);
    chk(tag, 32'(bus_error), 32'(m_err));
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] sz);
    address_bus   = a;
    data_size     = sz;
    write_address = 1'b1;
    cyc();
    write_address = 1'b0;
    m_addr = a;
    m_sz   = sz;
    m_sel  = f_hit(a);
    m_act  = 1'b1;
    chk("selected", 32'(selected), 32'(m_sel));
  endtask

  task automatic do_store(input logic [31:0] d);
    tb_dat = d;
    tb_drv = 1'b1;
    write  = 1'b1;
    cyc();
    write  = 1'b0;
    tb_drv = 1'b0;
    if (m_act && m_sel) begin
      if (f_legal()) model_store(d);
      else           m_err = 1'b1;
    end
    chk_err("store_err");
  endtask

  task automatic do_both(input logic [31:0] d);
    tb_dat = d;
    tb_drv = 1'b1;
    write  = 1'b1;
    read   = 1'b1;
    cyc();
    write  = 1'b0;
    read   = 1'b0;
    tb_drv = 1'b0;
    if (m_act && m_sel) m_err = 1'b1;
    chk_err("both_err");
  endtask

  task automatic do_load(input string tag, output logic [31:0] obs);
    read = 1'b1;
    cyc();
    obs = io_bus;
    if (m_act && m_sel && f_legal()) chk(tag, obs, f_word(m_addr));
    else                             chk_float(tag);
    if (m_act && m_sel && !f_legal()) m_err = 1'b1;
    read = 1'b0;
    chk_err("load_err");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_selected", 32'(selected), 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk_float("rst_io_bus");
    cyc();
    reset = 1'b1;
    m_act = 1'b0;
    m_sel = 1'b0;
    m_err = 1'b0;
  endtask

  logic [31:0] rd, a;
  int          r, k;
  logic [1:0]  sz;

  initial begin
    reset = 1'b0; address_bus = '0; data_size = '0; write_address = 1'b0;
    write = 1'b0; read = 1'b0; tb_drv = 1'b0; tb_dat = '0;
    m_act = 1'b0; m_sel = 1'b0; m_err = 1'b0; m_addr = '0; m_sz = '0;
    @(negedge clock);
    do_reset();

    // Access in IDLE is ignored without error.
    do_load("idle_read", rd);
    do_store(32'h1234_5678);

    // Word store then readback.
    addr_phase(BASE + 32'h10, 2'd2);
    do_store(32'hDEAD_BEEF);
    addr_phase(BASE + 32'h10, 2'd2);
    do_load("word_rd", rd);
    chk("word_rd_const", rd, 32'hDEAD_BEEF);

    // Byte store into lane 2, half store into lanes 0/1 via a re-latched address.
    do_store(32'h1122_3344);
    addr_phase(BASE + 32'h12, 2'd0);
    do_store(32'h00AA_0000);
    addr_phase(BASE + 32'h10, 2'd2);
    do_load("byte_merge", rd);
    chk("byte_merge_const", rd, 32'h11AA_3344);
    addr_phase(BASE + 32'h10, 2'd1);
    do_store(32'h0000_5566);
    do_load("half_merge", rd);
    chk("half_merge_const", rd, 32'h11AA_5566);

    // Region boundaries.
    addr_phase(BASE + 32'h0FFC, 2'd2);
    do_store(32'hA5A5_0F0F);
    do_load("last_word", rd);
    chk("last_word_const", rd, 32'hA5A5_0F0F);
    addr_phase(BASE + 32'h1000, 2'd2);
    do_load("above_region", rd);
    addr_phase(BASE - 32'd4, 2'd2);
    do_store(32'hFFFF_FFFF);
    do_load("below_region", rd);
    chk("no_err_unsel", 32'(bus_error), 32'h0);

    // Read and write together: suppressed, sticky error.
    addr_phase(BASE + 32'h10, 2'd2);
    do_both(32'h5555_5555);
    do_load("after_both", rd);
    chk("after_both_const", rd, 32'h11AA_5566);
    chk("sticky_err", 32'(bus_error), 32'h1);
    do_reset();

    // Reserved size on a selected read.
    addr_phase(BASE + 32'h10, 2'd3);
    do_load("size11", rd);
    chk("size11_err", 32'(bus_error), 32'h1);

    // Reset while a store is on the bus.
    addr_phase(BASE + 32'h20, 2'd2);
    do_store(32'hCAFE_F00D);
    addr_phase(BASE + 32'h20, 2'd2);
    tb_dat = 32'h1234_5678;
    tb_drv = 1'b1;
    write  = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("midrst_selected", 32'(selected), 32'h0);
    chk("midrst_bus_error", 32'(bus_error), 32'h0);
    tb_drv = 1'b0;
    #1;
    chk_float("midrst_io_bus");
    cyc();
    write = 1'b0;
    reset = 1'b1;
    m_act = 1'b0; m_sel = 1'b0; m_err = 1'b0;
    addr_phase(BASE + 32'h20, 2'd2);
    do_load("midrst_mem", rd);
    chk("midrst_mem_const", rd, 32'hCAFE_F00D);

    // Misaligned word store.
    addr_phase(BASE + 32'h12, 2'd2);
    do_store(32'h9988_7766);
    addr_phase(BASE + 32'h10, 2'd2);
    do_load("misalign", rd);
`ifdef ALIGN_CHECK_EN
    chk("misalign_const", rd, 32'h11AA_5566);
    chk("misalign_err", 32'(bus_error), 32'h1);
`else
    chk("misalign_const", rd, 32'h9988_7766);
    chk("misalign_err", 32'(bus_error), 32'h0);
`endif

    // Randomized phase over the first 16 words plus out-of-region addresses.
    do_reset();
    for (int w = 0; w < 16; w++) begin
      addr_phase(BASE + 32'(4 * w), 2'd2);
      do_store($urandom);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      if (!m_act ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) != 0)) begin
        r = $urandom_range(0, 19);
        if (r < 17)       a = BASE + 32'($urandom_range(0, 63));
        else if (r == 17) a = BASE - 32'd1 - 32'($urandom_range(0, 7));
        else              a = BASE + 32'h1000 + 32'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        sz = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
        addr_phase(a, sz);
      end
      k = $urandom_range(0, 9);
      if (k < 5)      do_store($urandom);
      else if (k < 9) do_load("rand_load", rd);
      else            do_both($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
